// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Fetch FSM encoding, the canonical NOP and the sequential PC increment.
package riscv_fetch_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] PC_STEP   = 32'd4;

  // Instruction fetches are word aligned; low address bits are forced to zero.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: flush beats hold, hold beats load, otherwise a bubble.
// A bubble or flush clears valid and inserts a NOP but keeps the last PC.
module if_id_register
  import riscv_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        Reset,
  input  logic        flush,
  input  logic        hold,
  input  logic        load,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc_in,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (Reset) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
    end else if (hold) begin
      valid <= valid;
      instr <= instr;
      pc    <= pc;
    end else if (load) begin
      valid <= 1'b1;
      instr <= instr_in;
      pc    <= pc_in;
    end else begin
      valid <= 1'b0;
      instr <= NOP_INSTR;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// RISC-V instruction fetch: one outstanding imem request, stall hold buffer,
// redirect flush with a drop flag for the in-flight response, next-PC control.
module instr_fetch_unit
  import riscv_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        Reset,
  input  logic [31:0] pc_cur,
  output logic [31:0] pc_next,
  output logic        pc_le,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc
);

  fetch_state_t state, state_d;
  logic         drop, drop_d;
  logic [31:0]  hold_buf, hold_buf_d;
  logic         ifid_flush, ifid_hold, ifid_load;
  logic [31:0]  ifid_load_instr;

  assign imem_addr = pc_cur;

  always_ff @(posedge clk) begin
    if (Reset) begin
      state    <= ST_FETCH;
      drop     <= 1'b0;
      hold_buf <= '0;
    end else begin
      state    <= state_d;
      drop     <= drop_d;
      hold_buf <= hold_buf_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case/if tree can leave a value unassigned and infer a latch.
    state_d         = state;
    drop_d          = drop;
    hold_buf_d      = hold_buf;
    imem_req        = 1'b0;
    pc_le           = 1'b0;
    pc_next         = pc_cur + PC_STEP;
    ifid_flush      = 1'b0;
    ifid_hold       = 1'b0;
    ifid_load       = 1'b0;
    ifid_load_instr = hold_buf;

    if (!Reset) begin
      ifid_flush = redirect;
      ifid_hold  = stall;
      if (redirect) begin
        pc_le   = 1'b1;
        pc_next = align_word(redirect_target);
      end

      unique case (state)
        ST_FETCH: begin
          imem_req = 1'b1;
          if (imem_gnt) begin
            state_d = ST_WAIT;
            // A granted request now targets the stale PC; its reply must be dropped.
            drop_d  = redirect;
          end
        end
        ST_WAIT: begin
          if (redirect) begin
            drop_d  = !imem_rvalid;
            if (imem_rvalid) state_d = ST_FETCH;
          end else if (imem_rvalid) begin
            state_d = ST_FETCH;
            if (drop) begin
              drop_d = 1'b0;
            end else if (!stall) begin
              ifid_load       = 1'b1;
              ifid_load_instr = imem_rdata;
              pc_le           = 1'b1;
            end else begin
              hold_buf_d = imem_rdata;
              state_d    = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (redirect) begin
            state_d = ST_FETCH;
          end else if (!stall) begin
            ifid_load = 1'b1;
            pc_le     = 1'b1;
            state_d   = ST_FETCH;
          end
        end
        default: state_d = ST_FETCH;
      endcase
    end
  end

  // PC is only advanced once the word is delivered, so pc_cur is still its address.
  if_id_register u_if_id (
    .clk      (clk),
    .Reset    (Reset),
    .flush    (ifid_flush),
    .hold     (ifid_hold),
    .load     (ifid_load),
    .instr_in (ifid_load_instr),
    .pc_in    (pc_cur),
    .valid    (ifid_valid),
    .instr    (ifid_instr),
    .pc       (ifid_pc)
  );

endmodule
